regfile_sb: RTL and testbench

- Parametrised successor to the 32x32 gate-level register bank.
- Provides DEPTH registers of DATA_W bits, two asynchronous read ports and one synchronous write port.
- Optional hardwired-zero register 0.
- Adds a per-register pending scoreboard for multi-cycle producers (loads, multiply) and a pending counter, so the issue stage can stall on read-after-write hazards.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 77 +++++++
 rtl/regfile_sb.sv | 79 +++++++
 tb/tb_regfile_sb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_sb register bank.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int DEPTH_DEF    = 32;
    localparam bit ZERO_REG_DEF = 1'b1;

    typedef logic [$clog2(DEPTH_DEF)-1:0] regAddrT;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for multi-cycle producers, reservation stall and pending count.
// Forwarding of the write's pend clear to busyN follows REGFILE_BYPASS_EN via regfile_pkg.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic              rsv_stall,
    output logic [ADDR_W:0]   pend_count
);

    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] pend;
    logic [ADDR_W:0]  pendCount;
    logic             wrLive;
    logic             rsvLive;
    logic             rsvAccept;
    logic             cntInc;
    logic             cntDec;

    function automatic logic isZero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Handshake: rsv_en is a request held by the issuer; the reservation is taken
    // on the edge where rsv_stall is 0, otherwise the issuer keeps rsv_en/rsv_addr stable and retries.
    always_comb begin
        wrLive    = wr_en && !isZero(wr_addr);
        rsvLive   = rsv_en && !isZero(rsv_addr);
        rsv_stall = rsvLive && pend[rsv_addr] && !(wr_en && (wr_addr == rsv_addr));
        rsvAccept = rsvLive && !rsv_stall;
        cntInc    = rsvAccept && !pend[rsv_addr];
        // A write that clears a bit the same-edge reservation re-sets is net zero.
        cntDec    = wrLive && pend[wr_addr] && !(rsvAccept && (wr_addr == rsv_addr));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend      <= '0;
            pendCount <= '0;
        end else begin
            if (wrLive)
                pend[wr_addr] <= 1'b0;
            if (rsvAccept)
                pend[rsv_addr] <= 1'b1;
            if (cntInc && !cntDec && (pendCount != MAX_COUNT))
                pendCount <= pendCount + 1'b1;
            else if (cntDec && !cntInc && (pendCount != '0))
                pendCount <= pendCount - 1'b1;
        end
    end

    always_comb begin
        busy1 = pend[rd_addr1] && !isZero(rd_addr1);
        busy2 = pend[rd_addr2] && !isZero(rd_addr2);
        if (BYPASS_EN && wrLive && (wr_addr == rd_addr1))
            busy1 = 1'b0;
        if (BYPASS_EN && wrLive && (wr_addr == rd_addr2))
            busy2 = 1'b0;
    end

    assign pend_count = pendCount;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register bank: two combinational read ports, one write port, RAW scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              busy1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_stall,
    output logic [ADDR_W:0]   pend_count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wrLive;

    function automatic logic isZero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    assign wrLive = wr_en && !isZero(wr_addr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wrLive) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Register 0 is forced to zero at the mux too, so it never depends on storage contents.
    always_comb begin
        rd_data1 = mem[rd_addr1];
        rd_data2 = mem[rd_addr2];
        if (isZero(rd_addr1))
            rd_data1 = '0;
        else if (BYPASS_EN && wrLive && (wr_addr == rd_addr1))
            rd_data1 = wr_data;
        if (isZero(rd_addr2))
            rd_data2 = '0;
        else if (BYPASS_EN && wrLive && (wr_addr == rd_addr2))
            rd_data2 = wr_data;
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .rsv_stall  (rsv_stall),
        .pend_count (pend_count)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: vector table plus hand sequences for bypass and reset corners.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [DATA_W-1:0] rd_data1, rd_data2, wr_data;
    logic              busy1, busy2, wr_en, rsv_en, rsv_stall;
    logic [ADDR_W:0]   pend_count;

    int total;
    int passed;
    logic [DATA_W-1:0] exp_q[$];

    regfile_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr1   (rd_addr1),
        .rd_data1   (rd_data1),
        .busy1      (busy1),
        .rd_addr2   (rd_addr2),
        .rd_data2   (rd_data2),
        .busy2      (busy2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rsv_stall  (rsv_stall),
        .pend_count (pend_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              wrEn;
        regAddrT           wa;
        logic [DATA_W-1:0] wd;
        logic              rsvEn;
        regAddrT           ra;
        regAddrT           r1;
        regAddrT           r2;
        logic [DATA_W-1:0] exp1;
        logic [DATA_W-1:0] exp2;
        logic              expB1;
        logic              expB2;
        logic              expStall;
        logic [ADDR_W:0]   expCnt;
    } vecT;

    vecT vecs[13];

    function automatic vecT mk(input logic we, input int wa, input logic [31:0] wd,
                               input logic re, input int ra, input int r1, input int r2,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic b1, input logic b2, input logic st, input int cnt);
        vecT v;
        v.wrEn = we;  v.wa = regAddrT'(wa);  v.wd = wd;
        v.rsvEn = re; v.ra = regAddrT'(ra);
        v.r1 = regAddrT'(r1); v.r2 = regAddrT'(r2);
        v.exp1 = e1; v.exp2 = e2; v.expB1 = b1; v.expB2 = b2;
        v.expStall = st; v.expCnt = (ADDR_W + 1)'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic we, input int wa, input logic [31:0] wd,
                         input logic re, input int ra, input int r1, input int r2);
        wr_en = we;   wr_addr = ADDR_W'(wa);   wr_data = wd;
        rsv_en = re;  rsv_addr = ADDR_W'(ra);
        rd_addr1 = ADDR_W'(r1); rd_addr2 = ADDR_W'(r2);
    endtask

    task automatic idle();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
    endtask

    // Inputs change on negedge; outputs checked 1 time unit later, before the next posedge.
    initial begin
        total = 0;
        passed = 0;
        reset = 1'b0;
        drive(1'b1, 3, 32'hFFFF_FFFF, 1'b1, 6, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle();

        for (int i = 0; i < DEPTH; i++) begin
            rd_addr1 = ADDR_W'(i);
            rd_addr2 = ADDR_W'(DEPTH - 1 - i);
            #1;
            check($sformatf("rst_data1[%0d]", i), 64'(rd_data1), 64'h0);
            check($sformatf("rst_data2[%0d]", i), 64'(rd_data2), 64'h0);
            check($sformatf("rst_busy[%0d]", i), 64'({busy1, busy2}), 64'h0);
        end
        check("rst_pend_count", 64'(pend_count), 64'h0);

        // Pre-edge expectations; state updates from row N are visible at row N+1.
        vecs[0]  = mk(0, 0, 32'h0,        0, 0, 0, 31, 32'h0,        32'h0,        0, 0, 0, 0);
        vecs[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 1, 2,  32'h0,        32'h0,        0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 32'h1234,     0, 0, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 32'h0,        1, 7, 0, 5,  32'h0,        32'hDEADBEEF, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 32'h0,        1, 7, 7, 7,  32'h0,        32'h0,        1, 1, 1, 1);
        vecs[5]  = mk(1, 7, 32'h55,       0, 0, 1, 2,  32'h0,        32'h0,        0, 0, 0, 1);
        vecs[6]  = mk(1, 9, 32'h99,       1, 9, 7, 7,  32'h55,       32'h55,       0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 32'h0,        1, 3, 9, 9,  32'h99,       32'h99,       1, 1, 0, 1);
        vecs[8]  = mk(1, 3, 32'h33,       1, 4, 9, 6,  32'h99,       32'h0,        1, 0, 0, 2);
        vecs[9]  = mk(1, 9, 32'h9,        1, 0, 3, 4,  32'h33,       32'h0,        0, 1, 0, 2);
        vecs[10] = mk(1, 4, 32'h44,       1, 4, 0, 9,  32'h0,        32'h9,        0, 0, 0, 1);
        vecs[11] = mk(1, 5, 32'h5,        1, 4, 4, 0,  32'h44,       32'h0,        1, 0, 1, 1);
        vecs[12] = mk(0, 0, 32'h0,        0, 0, 5, 4,  32'h5,        32'h44,       0, 1, 0, 1);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].wrEn, int'(vecs[i].wa), vecs[i].wd, vecs[i].rsvEn,
                  int'(vecs[i].ra), int'(vecs[i].r1), int'(vecs[i].r2));
            #1;
            check($sformatf("v%0d_rd_data1", i), 64'(rd_data1), 64'(vecs[i].exp1));
            check($sformatf("v%0d_rd_data2", i), 64'(rd_data2), 64'(vecs[i].exp2));
            check($sformatf("v%0d_busy1", i), 64'(busy1), 64'(vecs[i].expB1));
            check($sformatf("v%0d_busy2", i), 64'(busy2), 64'(vecs[i].expB2));
            check($sformatf("v%0d_rsv_stall", i), 64'(rsv_stall), 64'(vecs[i].expStall));
            check($sformatf("v%0d_pend_count", i), 64'(pend_count), 64'(vecs[i].expCnt));
            @(negedge clk);
        end

        // Same-cycle write/read of r12
        drive(1'b1, 12, 32'h1111_1111, 1'b0, 0, 0, 0);
        @(negedge clk);
        drive(1'b1, 12, 32'hA5A5_A5A5, 1'b0, 0, 0, 12);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", 64'(rd_data2), 64'hA5A5_A5A5);
`else
        check("bypass_same_cycle", 64'(rd_data2), 64'h1111_1111);
`endif
        @(negedge clk);
        idle();
        rd_addr2 = 5'd12;
        #1;
        check("bypass_next_cycle", 64'(rd_data2), 64'hA5A5_A5A5);

        // Randomised writes to r20..r23, read back from the expected queue
        for (int i = 20; i < 24; i++) begin
            logic [DATA_W-1:0] d;
            d = DATA_W'($urandom_range(32'hFFFF_FFFF, 0));
            exp_q.push_back(d);
            @(negedge clk);
            drive(1'b1, i, d, 1'b0, 0, 0, 0);
        end
        @(negedge clk);
        idle();
        for (int i = 20; i < 24; i += 2) begin
            rd_addr1 = ADDR_W'(i);
            rd_addr2 = ADDR_W'(i + 1);
            #1;
            check($sformatf("sb_r%0d", i), 64'(rd_data1), 64'(exp_q.pop_front()));
            check($sformatf("sb_r%0d", i + 1), 64'(rd_data2), 64'(exp_q.pop_front()));
        end

        // Reset while reservations are outstanding (r4 still pending from the table)
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive(1'b0, 0, 32'h0, 1'b1, i, 0, 0);
        end
        @(negedge clk);
        idle();
        rd_addr1 = 5'd2;
        #1;
        check("pre_reset_pend_count", 64'(pend_count), 64'd4);
        check("pre_reset_busy_r2", 64'(busy1), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2, 32'hFF, 1'b1, 5, 2, 5);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 0, 32'h0, 1'b1, 1, 2, 5);
        #1;
        check("post_reset_pend_count", 64'(pend_count), 64'd0);
        check("post_reset_r2", 64'(rd_data1), 64'h0);
        check("post_reset_r5", 64'(rd_data2), 64'h0);
        check("post_reset_busy", 64'({busy1, busy2}), 64'h0);
        check("post_reset_rsv_stall", 64'(rsv_stall), 64'h0);
        @(negedge clk);
        idle();
        rd_addr1 = 5'd1;
        #1;
        check("post_reset_rsv_busy_r1", 64'(busy1), 64'd1);
        check("post_reset_rsv_count", 64'(pend_count), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
